// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has the port, auxiliary results queue up and drain into idle cycles.
// Build option: define REGFILE_ARB_STARVE_GUARD_EN to force a queued result out after STARVE_LIMIT blocked cycles.
module regfile_write_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                pipeValid,
   input  logic                                pipeEnable,
   input  logic [4:0]                          pipeAddress,
   input  logic [31:0]                         pipeData,
   input  logic                                auxValid,
   output logic                                auxReady,
   input  logic [4:0]                          auxAddress,
   input  logic [31:0]                         auxData,
   output logic                                pipeStall,
   output logic                                destinationEnable,
   output logic [4:0]                          writeAddress,
   output logic [31:0]                         writeData,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     pendingCount
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < 1 || STARVE_LIMIT < 1) begin : g_bad_param
      $error("regfile_write_arbiter: FIFO_DEPTH and STARVE_LIMIT must both be >= 1");
   end

   // Queue is kept compacted: slot 0 is always the head, slots below r_count are live.
   logic [4:0]           r_addr [FIFO_DEPTH];
   logic [31:0]          r_data [FIFO_DEPTH];
   logic [CW-1:0]        r_count;

   logic                 w_pipe_write;
   logic                 w_q_avail;
   logic                 w_force;
   logic                 w_pipe_grant;
   logic                 w_pop;
   logic                 w_accept;
   logic                 w_store;
   logic [FIFO_DEPTH-1:0] w_live;
   logic [FIFO_DEPTH-1:0] w_squash;
   logic [FIFO_DEPTH-1:0] w_keep;
   logic [4:0]           w_n_addr [FIFO_DEPTH];
   logic [31:0]          w_n_data [FIFO_DEPTH];
   logic [CW-1:0]        w_n_count;

   assign w_pipe_write = pipeValid && pipeEnable && (pipeAddress != 5'd0);
   // A reset cycle must not drain a queued entry onto the port.
   assign w_q_avail    = (r_count != '0) && !reset;
   assign w_pipe_grant = w_pipe_write && !w_force;
   assign w_pop        = w_q_avail && (w_force || !w_pipe_write);

   assign auxReady     = (r_count < CW'(FIFO_DEPTH));
   assign w_accept     = auxValid && auxReady;
   assign w_store      = w_accept && (auxAddress != 5'd0);
   assign pendingCount = r_count;

   genvar gi;
   for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      assign w_live[gi]   = (CW'(gi) < r_count);
      assign w_squash[gi] = w_pipe_grant && w_live[gi] && (r_addr[gi] == pipeAddress);
      if (gi == 0) begin : g_head
         assign w_keep[gi] = w_live[gi] && !w_squash[gi] && !w_pop;
      end else begin : g_body
         assign w_keep[gi] = w_live[gi] && !w_squash[gi];
      end
   end

   always_comb begin
      destinationEnable = 1'b0;
      writeAddress      = 5'd0;
      writeData         = 32'd0;
      if (w_pipe_grant) begin
         destinationEnable = 1'b1;
         writeAddress      = pipeAddress;
         writeData         = pipeData;
      end else if (w_pop) begin
         destinationEnable = 1'b1;
         writeAddress      = r_addr[0];
         writeData         = r_data[0];
      end
   end

   // Survivors slide down in age order; the new entry lands just above them.
   always_comb begin : compact
      logic [CW-1:0] rank;
      rank = '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
         w_n_addr[j] = r_addr[j];
         w_n_data[j] = r_data[j];
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            if (w_keep[i] && rank == CW'(j)) begin
               w_n_addr[j] = r_addr[i];
               w_n_data[j] = r_data[i];
            end
         end
         rank = rank + CW'(w_keep[i]);
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
         if (w_store && rank == CW'(j)) begin
            w_n_addr[j] = auxAddress;
            w_n_data[j] = auxData;
         end
      end
      w_n_count = rank + CW'(w_store);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_n_count;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         r_addr[i] <= w_n_addr[i];
         r_data[i] <= w_n_data[i];
      end
   end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] r_starve;

   assign w_force   = w_q_avail && (r_starve == SW'(STARVE_LIMIT));
   assign pipeStall = w_force && w_pipe_write;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_starve <= '0;
      end else if (r_count == '0 || w_pop || w_squash[0]) begin
         r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
         r_starve <= r_starve + SW'(1);
      end
   end
`else
   assign w_force   = 1'b0;
   assign pipeStall = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic, checked every cycle against a queue-level model.
module tb_regfile_write_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        pipeValid, pipeEnable, auxValid;
   logic [4:0]  pipeAddress, auxAddress;
   logic [31:0] pipeData, auxData;
   logic        auxReady, pipeStall, destinationEnable;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic [$clog2(DEPTH+1)-1:0] pendingCount;

   always #5 clock = ~clock;

   regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .pipeValid(pipeValid), .pipeEnable(pipeEnable), .pipeAddress(pipeAddress), .pipeData(pipeData),
      .auxValid(auxValid), .auxReady(auxReady), .auxAddress(auxAddress), .auxData(auxData),
      .pipeStall(pipeStall), .destinationEnable(destinationEnable),
      .writeAddress(writeAddress), .writeData(writeData), .pendingCount(pendingCount)
   );

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: an ordered list of pending results plus a blocked-cycle counter.
   logic [4:0]  q_addr[$];
   logic [31:0] q_data[$];
   int          m_starve = 0;

   logic        o_en, o_stall, o_ready;
   logic [4:0]  o_addr;
   logic [31:0] o_data;
   logic [31:0] o_count;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic pe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic av, input logic [4:0] aa, input logic [31:0] ad);
      pipeValid = pv; pipeEnable = pe; pipeAddress = pa; pipeData = pd;
      auxValid = av; auxAddress = aa; auxData = ad;
   endtask

   task automatic tick();
      bit pw, ne, frc, gp, pop, acc, hsq;
      logic        e_en;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      #2;
      o_en = destinationEnable; o_stall = pipeStall; o_ready = auxReady;
      o_addr = writeAddress; o_data = writeData; o_count = 32'(pendingCount);
      pw  = pipeValid && pipeEnable && pipeAddress != 5'd0;
      ne  = (q_addr.size() > 0) && !reset;
      frc = GUARD && ne && (m_starve == LIMIT);
      gp  = pw && !frc;
      pop = ne && (frc || !pw);
      e_en = gp || pop;
      e_addr = gp ? pipeAddress : (pop ? q_addr[0] : 5'd0);
      e_data = gp ? pipeData    : (pop ? q_data[0] : 32'd0);
      chk("destinationEnable", 32'(o_en), 32'(e_en));
      chk("writeAddress", 32'(o_addr), 32'(e_addr));
      chk("writeData", o_data, e_data);
      chk("pipeStall", 32'(o_stall), 32'(frc && pw));
      chk("auxReady", 32'(o_ready), 32'(q_addr.size() < DEPTH));
      chk("pendingCount", o_count, 32'(q_addr.size()));
      if (reset) begin
         q_addr.delete(); q_data.delete(); m_starve = 0;
      end else begin
         acc = auxValid && (q_addr.size() < DEPTH);
         hsq = gp && (q_addr.size() > 0) && (q_addr[0] == pipeAddress);
         if (q_addr.size() == 0 || pop || hsq) m_starve = 0;
         else if (m_starve < LIMIT) m_starve++;
         if (pop) begin
            void'(q_addr.pop_front()); void'(q_data.pop_front());
         end
         if (gp) begin
            for (int i = q_addr.size() - 1; i >= 0; i--) begin
               if (q_addr[i] == pipeAddress) begin
                  q_addr.delete(i); q_data.delete(i);
               end
            end
         end
         if (acc && auxAddress != 5'd0) begin
            q_addr.push_back(auxAddress); q_data.push_back(auxData);
         end
      end
      @(posedge clock); #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clock); #1;
      tick();
      reset = 1'b0;

      // reset state, then zero-latency pipe write
      tick();
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_count", o_count, 32'd0);
      chk("rst_en", 32'(o_en), 32'd0);
      drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      tick();
      chk("pipe_en", 32'(o_en), 32'd1);
      chk("pipe_addr", 32'(o_addr), 32'd5);
      chk("pipe_data", o_data, 32'hDEADBEEF);

      // aux accepted in an idle cycle lands one cycle later
      drive(0, 0, 0, 0, 1, 5'd7, 32'h11);
      tick();
      chk("aux_no_bypass", 32'(o_en), 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("aux_addr", 32'(o_addr), 32'd7);
      chk("aux_data", o_data, 32'h11);
      tick();
      chk("aux_drained", o_count, 32'd0);

      // fill under a pipe stream, third offer refused, drain in order
      drive(1, 1, 5'd20, 32'h2020, 1, 5'd3, 32'hA);
      tick();
      drive(1, 1, 5'd20, 32'h2021, 1, 5'd4, 32'hB);
      tick();
      drive(1, 1, 5'd20, 32'h2022, 1, 5'd8, 32'hC);
      tick();
      chk("full_ready", 32'(o_ready), 32'd0);
      chk("full_count", o_count, 32'd2);
      drive(1, 1, 5'd20, 32'h2023, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("drain1_addr", 32'(o_addr), 32'd3);
      chk("drain1_data", o_data, 32'hA);
      tick();
      chk("drain2_addr", 32'(o_addr), 32'd4);
      chk("drain2_data", o_data, 32'hB);
      tick();
      chk("refused_not_written", 32'(o_en), 32'd0);

      // WAW squash
      drive(1, 1, 5'd21, 32'h1, 1, 5'd9, 32'h55);
      tick();
      drive(1, 1, 5'd9, 32'h66, 0, 0, 0);
      tick();
      chk("squash_data", o_data, 32'h66);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("squash_count", o_count, 32'd0);
      chk("squash_no_write", 32'(o_en), 32'd0);

`ifdef REGFILE_ARB_STARVE_GUARD_EN
      drive(1, 1, 5'd22, 32'h77, 1, 5'd2, 32'h1);
      tick();
      drive(1, 1, 5'd22, 32'h77, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("starve_wait_stall", 32'(o_stall), 32'd0);
      end
      tick();
      chk("starve_force_addr", 32'(o_addr), 32'd2);
      chk("starve_force_stall", 32'(o_stall), 32'd1);
      tick();
      chk("starve_held_addr", 32'(o_addr), 32'd22);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
`endif

      // x0 aux result is consumed and discarded
      drive(0, 0, 0, 0, 1, 5'd0, 32'h123);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("x0_count", o_count, 32'd0);
      chk("x0_en", 32'(o_en), 32'd0);

      // reset with two entries queued
      drive(1, 1, 5'd23, 32'h5, 1, 5'd10, 32'hAA);
      tick();
      drive(1, 1, 5'd23, 32'h6, 1, 5'd11, 32'hBB);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      chk("rst_mid_en", 32'(o_en), 32'd0);
      reset = 1'b0;
      tick();
      chk("rst_mid_count", o_count, 32'd0);
      chk("rst_mid_en2", 32'(o_en), 32'd0);

      // random traffic on a small address set to provoke squashes and x0 results
      for (int k = 0; k < 500; k++) begin
         drive(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         reset = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
